mul_acc: RTL

Multiply-accumulate stage directly downstream of the combinational 32-bit `mul` unit. It consumes a stream of 32-bit products (`mul` output `C`) over a valid/ready handshake and sums a programmed number of them into a wide accumulator. It returns the sum over a second valid/ready handshake. Typical use is dot-products and scaled sums, with `mul` operands driven by the upstream sequencer.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_acc_add.sv | 32 +++
 rtl/mul_acc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply-accumulate stage that sits behind the 32-bit mul unit.
//   mul_acc_state_e : FSM state encoding for mul_acc (idle / accumulating / result pending)
//   MUL_PROD_W      : width of a product coming from mul.C
//   MUL_ACC_W_DEF   : default accumulator width
package mul_pkg;

    localparam int unsigned MUL_PROD_W    = 32;
    localparam int unsigned MUL_ACC_W_DEF = 48;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } mul_acc_state_e;

endpackage

// File: rtl/mul_acc_add.sv
// ACC_W-bit unsigned adder: acc + zero-extended 32-bit product.
// Build option: MUL_ACC_SAT_EN -- when defined, a carry-out clamps the sum to all-ones;
// otherwise the sum wraps modulo 2^ACC_W. The carry-out is reported in both builds.
//   acc_i  : current accumulator value
//   prod_i : unsigned product to add
//   sum_o  : new accumulator value (wrapped or saturated)
//   ovf_o  : carry-out of the ACC_W-bit addition
module mul_acc_add
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W = MUL_ACC_W_DEF
) (
    input  logic [ACC_W-1:0]      acc_i,
    input  logic [MUL_PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]      sum_o,
    output logic                  ovf_o
);

    logic [ACC_W:0] sum_full;

    // One extra bit captures the carry-out.
    assign sum_full = {1'b0, acc_i} + {{(ACC_W + 1 - MUL_PROD_W){1'b0}}, prod_i};
    assign ovf_o    = sum_full[ACC_W];

`ifdef MUL_ACC_SAT_EN
    // Once clamped, any further nonzero product carries out again, so the value stays pinned.
    assign sum_o = ovf_o ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign sum_o = sum_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_acc.sv
// Multiply-accumulate stage: sums a programmed number of 32-bit products from the mul unit
// into an ACC_W-bit accumulator and hands back the total over a valid/ready handshake.
// Build option: MUL_ACC_SAT_EN (see mul_acc_add) selects saturating instead of wrapping sums.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start_i      : job request, honoured only when idle
//   len_i        : number of products in the job, sampled with start_i
//   prod_valid_i : product present on prod_i
//   prod_ready_o : product accepted this cycle
//   prod_i       : unsigned 32-bit product
//   res_valid_o  : result available
//   res_ready_i  : downstream takes the result
//   res_o        : accumulated sum
//   ovf_o        : job overflowed ACC_W (meaningful while res_valid_o is high)
//   busy_o       : block is not idle
module mul_acc
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W = MUL_ACC_W_DEF,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      len_i,
    input  logic                  prod_valid_i,
    output logic                  prod_ready_o,
    input  logic [MUL_PROD_W-1:0] prod_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ACC_W-1:0]      res_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    mul_acc_state_e   state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    mul_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (acc_q),
        .prod_i (prod_i),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        len_d   = len_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StAccum;
                    end else begin
                        // Empty job: report a zero sum without visiting ACCUM.
                        res_d   = '0;
                        state_d = StDone;
                    end
                end
            end

            StAccum: begin
                // prod_ready is implied by this state, so valid alone is a beat.
                if (prod_valid_i) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        res_d   = add_sum;
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign prod_ready_o = (state_q == StAccum);
    assign res_valid_o  = (state_q == StDone);
    assign busy_o       = (state_q != StIdle);
    assign res_o        = res_q;
    assign ovf_o        = ovf_q;

endmodule
